// File: rtl/alu_rotate_sequencer.sv
// Multi-cycle rotate sequencer driving a single-bit-rotate ALU.
// Iterates ROL/ROR by one per cycle, feeding alu_r back as alu_a.
module alu_rotate_sequencer #(
    parameter int unsigned COUNT_BITS  = 5,
    parameter logic [3:0]  ALU_OP_IDLE = 4'd0,
    parameter logic [3:0]  ALU_OP_ROL  = 4'd6,
    parameter logic [3:0]  ALU_OP_ROR  = 4'd7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        dir,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry_out,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_MASK = 8'((1 << COUNT_BITS) - 1);

    state_t                state_q;
    logic [15:0]           work_q;
    logic [COUNT_BITS-1:0] cnt_q;
    logic                  dir_q;
    logic [15:0]           result_q;
    logic                  carry_out_q;
    logic                  busy_q;
    logic                  done_q;

    logic [COUNT_BITS-1:0] cnt_in;
    logic                  rot_bit;

    // Only the low count bits matter; upper bits are architecturally ignored.
    assign cnt_in  = COUNT_BITS'(count & CNT_MASK);
    // Bit that the current single-step rotate moved around the word.
    assign rot_bit = dir_q ? alu_r[15] : alu_r[0];

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        work_q <= operand;
                        dir_q  <= dir;
                        cnt_q  <= cnt_in;
                        busy_q <= 1'b1;
                        if (cnt_in != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            // Zero count: word passes through, CF untouched.
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= operand;
                        end
                    end
                end
                S_RUN: begin
                    work_q <= alu_r;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == COUNT_BITS'(1)) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        result_q    <= alu_r;
                        carry_out_q <= rot_bit;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ALU operand steering depends only on internal state.
    always_comb begin
        alu_op = ALU_OP_IDLE;
        alu_a  = '0;
        if (state_q == S_RUN) begin
            alu_op = dir_q ? ALU_OP_ROR : ALU_OP_ROL;
            alu_a  = work_q;
        end
    end

    assign alu_b     = 16'h0000;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_alu_rotate_sequencer.sv
// Scoreboard bench for alu_rotate_sequencer with a behavioural ALU.
// Directed corner cases followed by randomized rotate operations.
module tb_alu_rotate_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        dir;
    logic [15:0] operand;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_r;

    typedef struct {
        logic [15:0] r;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic cf_m = 1'b0;

    alu_rotate_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dir       (dir),
        .operand   (operand),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_r     (alu_r)
    );

    // Single-cycle ALU: only the ops the sequencer uses.
    always_comb begin
        alu_r = alu_a & alu_b;
        if (alu_op == 4'd6) alu_r = {alu_a[14:0], alu_a[15]};
        if (alu_op == 4'd7) alu_r = {alu_a[0], alu_a[15:1]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Rotate by k positions as one arithmetic step.
    function automatic logic [15:0] rot(input logic [15:0] v, input logic d,
                                        input int k);
        logic [31:0] w;
        int          s;
        s = k % 16;
        w = {v, v};
        if (d) return w[s +: 16];
        return w[(16 - s) +: 16];
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)",
                         cyc);
            end else begin
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("carry_out", 32'(carry_out), 32'(e.c));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_in_done", 32'(busy), 32'd1);
                chk("alu_b", 32'(alu_b), 32'd0);
            end
        end
    end

    // Issue one op from an IDLE negedge; returns at the first IDLE negedge.
    task automatic run_op(input logic d, input logic [15:0] op,
                          input logic [7:0] c, input bit spur,
                          input int abort_at);
        int          n;
        int          k;
        bit          seen;
        logic [15:0] er;
        logic        ec;
        exp_t        e;
        n  = int'(c & 8'h1F);
        er = rot(op, d, n);
        ec = (n == 0) ? cf_m : (d ? er[15] : er[0]);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_alu_op", 32'(alu_op), 32'd0);
        chk("idle_alu_a", 32'(alu_a), 32'd0);
        start   = 1'b1;
        dir     = d;
        operand = op;
        count   = c;
        @(posedge clk);
        #1;
        k = cyc;
        if (abort_at == 0) begin
            e.r   = er;
            e.c   = ec;
            e.cyc = k + n;
            sb_q.push_back(e);
            cf_m = ec;
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (abort_at == i) begin
                reset_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_result", 32'(result), 32'd0);
                chk("abort_carry", 32'(carry_out), 32'd0);
                cf_m = 1'b0;
                @(negedge clk);
                start   = 1'b0;
                reset_n = 1'b1;
                return;
            end
            if (i <= n) begin
                chk("run_alu_a", 32'(alu_a), 32'(rot(op, d, i - 1)));
                chk("run_alu_op", 32'(alu_op), d ? 32'd7 : 32'd6);
            end
            chk("busy", 32'(busy), 32'd1);
            if (done) seen = 1'b1;
            if (spur) begin
                start   = 1'($urandom_range(0, 1));
                dir     = 1'($urandom);
                operand = 16'($urandom);
                count   = 8'($urandom);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        operand = '0;
        count   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        reset_n = 1'b1;

        run_op(1'b0, 16'h8001, 8'd1, 1'b0, 0);
        run_op(1'b1, 16'h0001, 8'd4, 1'b0, 0);
        run_op(1'b0, 16'h8001, 8'd1, 1'b0, 0);
        run_op(1'b0, 16'h1234, 8'h00, 1'b0, 0);
        run_op(1'b1, 16'h1234, 8'h20, 1'b0, 0);
        run_op(1'b0, 16'h4000, 8'h21, 1'b0, 0);
        run_op(1'b0, 16'h1235, 8'd16, 1'b0, 0);
        run_op(1'b1, 16'hA5C3, 8'd31, 1'b0, 0);
        run_op(1'b0, 16'h00F1, 8'd3, 1'b1, 0);
        run_op(1'b1, 16'h1357, 8'd2, 1'b1, 0);
        run_op(1'b0, 16'hBEEF, 8'd5, 1'b0, 2);
        run_op(1'b1, 16'h0F0F, 8'd6, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(1'($urandom), 16'($urandom), 8'($urandom),
                   1'($urandom), 0);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rotate_sequencer.md
Name: alu_rotate_sequencer

Overview:
- Multi-cycle sequencer that sits directly upstream of the single-cycle 16-bit ALU. It also consumes the ALU result.
- Implements rotate-by-count (ROL/ROR by CL or immediate) by issuing the ALU's single-bit rotate op once per cycle and feeding each result back as the next A operand.
- Reports the final word and the last bit rotated out (CF) to the execution unit with a one-cycle done pulse.

Parameters:
- COUNT_BITS, 5, number of low count bits used; the count is masked to this width, as on the V30.
- ALU_OP_IDLE, 4'd0, opcode driven on alu_op when not rotating (AND, side-effect free).
- ALU_OP_ROL, 4'd6, ALU rotate-left-by-one opcode.
- ALU_OP_ROR, 4'd7, ALU rotate-right-by-one opcode.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- dir  in  1  0 = ROL, 1 = ROR; latched on accepted start.
- operand  in  16  word to rotate; latched on accepted start.
- count  in  8  rotate count (CL/imm8); only count[COUNT_BITS-1:0] is latched.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and carry_out are valid from this cycle.
- result  out  16  final rotated word, held until the next accepted start or reset.
- carry_out  out  1  last bit rotated out, held like result.
- alu_op  out  4  ALU opcode.
- alu_a  out  16  ALU A operand.
- alu_b  out  16  ALU B operand, constant 16'h0000.
- alu_r  in  16  ALU result, combinational from alu_op/alu_a.

Behaviour:
- Reset (async assert, sync release): state = IDLE. work, cnt, result = 0. carry_out = 0, done = 0, busy = 0.
- Reset mid-RUN aborts the operation with no done pulse. A start seen in the first cycle after release is accepted.
- States are IDLE, RUN and DONE.
- IDLE:
  - alu_op = ALU_OP_IDLE, alu_a = 0.
  - On start=1: work <= operand, dir_q <= dir, cnt <= masked count.
  - If the masked count is non-zero, go to RUN. Otherwise go to DONE with work unchanged.
- RUN:
  - alu_op = dir_q ? ALU_OP_ROR : ALU_OP_ROL, alu_a = work.
  - Each edge: work <= alu_r, cnt <= cnt-1, carry_q <= dir_q ? alu_r[15] : alu_r[0].
  - When cnt==1 at the edge, go to DONE.
- DONE:
  - done = 1, busy = 1, alu_op = ALU_OP_IDLE.
  - result <= work and carry_out <= carry_q are registered on the RUN->DONE or IDLE->DONE edge, so they are visible during DONE.
  - Next state is always IDLE.
- Latency: a start accepted at edge 0 with masked count N>0 gives done high in the cycle after edge N+... precisely, state is RUN for N cycles and done is high in cycle N+1. For N=0, done is high in cycle 1.
- Masked count 0: result = operand, carry_out keeps its previous value (CF unaffected).
- Counts of 16 and above (up to 31) rotate fully; no shortcutting.
- start while busy (RUN or DONE) is ignored and is not queued. dir, operand and count are don't-care outside an accepted start.
- alu_b is always 16'h0000. No outputs have combinational paths from start, dir, operand or count.

Test Plan:
- ROL 16'h8001 by count 1 -> done in cycle 2, result 16'h0003, carry_out 1, busy high for cycles 1-2.
- ROR 16'h0001 by count 4 -> four RUN cycles with alu_a 0001, 8000, 4000, 2000; result 16'h1000, carry_out 0.
- Count 8'h00, then count 8'h20 (masked to 0), each on 16'h1234 with carry_out preset to 1 -> done in cycle 1, result 16'h1234, carry_out stays 1.
- Count 8'h21 (masked to 1) ROL 16'h4000 -> result 16'h8000, carry_out 0. Count 16 ROL 16'h1235 -> result 16'h1235, carry_out 1.
- start re-pulsed in RUN and in DONE with different operand -> ignored, first result unaffected. Back-to-back start in the first IDLE cycle after done -> accepted.
- reset_n low in RUN cycle 2 of a count-5 op -> immediate IDLE, result 0, carry_out 0, no done pulse. After release, a new start completes normally.
